// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline stage: occupancy state encoding and default widths.
package pipe_pkg;

   localparam int unsigned PIPE_DATA_W = 104;
   localparam int unsigned STALL_CNT_W = 32;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } pipe_state_e;

   // Main register holds a live payload in every state except EMPTY.
   function automatic logic state_has_main(input pipe_state_e s);
      return s != EMPTY;
   endfunction

   // Upstream may push whenever the skid register is free.
   function automatic logic state_can_accept(input pipe_state_e s);
      return s != FULL;
   endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Valid/ready handshake bundle for one pipeline stage: upstream push side plus downstream pop side.
interface pipe_skid_stage_if
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = PIPE_DATA_W
);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;

   // Producer/consumer environment around the stage.
   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );

   // The stage itself.
   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );

endinterface

// File: rtl/pipe_stall_counter.sv
// Saturating count of cycles the stage output is held by downstream back-pressure; cleared only by reset.
module pipe_stall_counter
   import pipe_pkg::*;
#(
   parameter int unsigned CNT_W = STALL_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Stop at all-ones rather than wrapping back to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (stall_i && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry (main + skid) pipeline register with fully registered valid/ready; flush empties the stage.
// Optional back-pressure counter is built when PIPE_STALL_CNT_EN is defined.
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = PIPE_DATA_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   pipe_skid_stage_if.slave       bus
`ifdef PIPE_STALL_CNT_EN
   ,
   output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

   pipe_state_e       state_q;
   pipe_state_e       state_d;
   logic [DATA_W-1:0] main_q;
   logic [DATA_W-1:0] main_d;
   logic [DATA_W-1:0] skid_q;
   logic [DATA_W-1:0] skid_d;
   logic              out_valid_q;
   logic              out_valid_d;
   logic              in_ready_q;
   logic              in_ready_d;
   logic              accept_c;
   logic              issue_c;

   assign accept_c = bus.in_valid && in_ready_q;
   assign issue_c  = out_valid_q && bus.out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   // Occupancy transitions; handshake flags are precomputed from the next state so they leave flops.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;

      unique case (state_q)
         EMPTY: begin
            if (accept_c) begin
               state_d = ONE;
               main_d  = bus.in_data;
            end
         end
         ONE: begin
            if (accept_c && issue_c) begin
               main_d = bus.in_data;
            end else if (issue_c) begin
               state_d = EMPTY;
            end else if (accept_c) begin
               state_d = FULL;
               skid_d  = bus.in_data;
            end
         end
         FULL: begin
            if (issue_c) begin
               state_d = ONE;
               main_d  = skid_q;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase

      // Flush only kills occupancy; stale data stays behind out_valid = 0.
      if (flush) begin
         state_d = EMPTY;
         main_d  = main_q;
         skid_d  = skid_q;
      end

      out_valid_d = state_has_main(state_d);
      in_ready_d  = state_can_accept(state_d);
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = main_q;
   assign bus.in_ready  = in_ready_q;

`ifdef PIPE_STALL_CNT_EN
   logic stall_c;

   assign stall_c = out_valid_q && !bus.out_ready;

   pipe_stall_counter #(
      .CNT_W (STALL_CNT_W)
   ) u_stall_counter (
      .clk     (clk),
      .reset   (reset),
      .stall_i (stall_c),
      .cnt_o   (stall_cnt)
   );
`endif

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 104, giving the width of the stage payload (a packed MEM/WB-style control + data bundle).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  kills every entry held in the stage.
REQ-005 SHALL have port in_valid  input  1  upstream payload present.
REQ-006 SHALL have port in_ready  output  1  stage can accept a payload this cycle.
REQ-007 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-008 SHALL have port out_valid  output  1  out_data holds a live payload.
REQ-009 SHALL have port out_ready  input  1  downstream consumes the payload this cycle.
REQ-010 SHALL have port out_data  output  DATA_W  payload to downstream.
REQ-011 SHALL have port stall_cnt  output  32  downstream back-pressure cycle count, present only under PIPE_STALL_CNT_EN.

Function
REQ-012 SHALL hold a main register (drives out_data/out_valid) and a one-entry skid register.
REQ-013 SHALL define accept = in_valid && in_ready and issue = out_valid && out_ready.
REQ-014 SHALL drive in_ready from a flop, equal to "skid register empty"; never combinationally from out_ready.
REQ-015 SHALL implement states EMPTY (main invalid), ONE (main valid, skid empty), FULL (both valid).
REQ-016 EMPTY: accept -> ONE, main <= in_data; otherwise hold.
REQ-017 ONE: accept && issue -> ONE, main <= in_data; issue only -> EMPTY; accept only -> FULL, skid <= in_data; neither -> hold.
REQ-018 FULL: in_ready = 0; issue -> ONE, main <= skid; otherwise hold.
REQ-019 SHALL have latency of exactly 1 cycle: payload accepted in cycle N appears on out_data in cycle N+1 when the stage was EMPTY or issuing.
REQ-020 SHALL keep out_data and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL preserve order; no payload lost or duplicated; sustain 1 payload/cycle when out_ready stays high.
REQ-022 flush SHALL take priority over accept/issue: next cycle EMPTY, in_ready = 1, the payload presented with flush is discarded; data registers keep old values (out_valid = 0 masks them).

Reset
REQ-023 reset SHALL dominate flush and all handshakes.
REQ-024 Reset values SHALL be: out_valid 0, in_ready 1, out_data 0, skid register 0, state EMPTY, stall_cnt 0.
REQ-025 Reset asserted mid-transfer SHALL drop all held payloads without emitting them.

Configuration
REQ-026 Macro PIPE_STALL_CNT_EN defined: stall_cnt increments each cycle out_valid && !out_ready, saturates at 0xFFFFFFFF, cleared only by reset (not flush).
REQ-027 Macro PIPE_STALL_CNT_EN undefined: stall_cnt port and counter logic SHALL be absent; handshake behaviour identical.

Structure
REQ-028 Shared package pipe_pkg SHALL hold the state encoding (EMPTY, ONE, FULL) and the default DATA_W constant 104.
REQ-029 Counter SHALL be sub-module pipe_stall_counter, instantiated only under PIPE_STALL_CNT_EN.

Verification
REQ-030 Reset then idle: out_valid = 0, in_ready = 1, out_data = 0, stall_cnt = 0.
REQ-031 Streaming: in_valid = 1, out_ready = 1, payloads 1..8 -> out_data 1..8 on consecutive cycles, first one cycle after accept.
REQ-032 Back-pressure: push 0xA, 0xB with out_ready = 0 -> FULL, in_ready = 0, out_data held at 0xA; raise out_ready -> 0xA then 0xB emitted, in_ready returns 1.
REQ-033 Flush while FULL with in_valid = 1 (payload 0xC) -> next cycle out_valid = 0, in_ready = 1, 0xC never emitted.
REQ-034 Stall count: out_valid held with out_ready = 0 for 5 cycles -> stall_cnt = 5; counter preset near max -> holds at 0xFFFFFFFF.
REQ-035 Random valid/ready with occasional flush vs scoreboard: order kept, no loss/duplication outside flushed entries.
